// File: rtl/rv_fetch_queue.sv
// rtl/rv_fetch_queue.sv - IF/ID instruction fetch queue with valid/ready handshakes and branch flush
// Circular buffer of {pc, pc+4, inst, misaligned}; head read combinationally, NOP shown when empty.
module rv_fetch_queue #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     ILEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     AFULL_LVL = DEPTH - 1,
  parameter logic [ILEN-1:0] NOP_INST  = 32'h0000_0013
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [XLEN-1:0]            i_in_pc,
  input  logic [XLEN-1:0]            i_in_pc_plus4,
  input  logic [ILEN-1:0]            i_in_inst,
  input  logic                       i_in_misaligned,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [XLEN-1:0]            o_out_pc,
  output logic [XLEN-1:0]            o_out_pc_plus4,
  output logic [ILEN-1:0]            o_out_inst,
  output logic                       o_out_misaligned,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_afull
);

  localparam int unsigned     PW         = $clog2(DEPTH);
  localparam int unsigned     CW         = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   LP_FULL    = CW'(DEPTH);
  localparam logic [CW-1:0]   LP_AFULL   = CW'(AFULL_LVL);
  localparam logic [CW-1:0]   LP_CNT_ONE = CW'(1);
  localparam logic [PW-1:0]   LP_PTR_ONE = PW'(1);

  logic [XLEN-1:0]  r_pc_mem   [DEPTH];
  logic [XLEN-1:0]  r_pc4_mem  [DEPTH];
  logic [ILEN-1:0]  r_inst_mem [DEPTH];
  logic [DEPTH-1:0] r_mis_mem;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Readiness comes only from registered occupancy, so no out_ready -> in_ready path exists.
  assign w_full      = (r_count == LP_FULL);
  assign w_empty     = (r_count == '0);
  assign o_in_ready  = ~w_full;
  assign o_out_valid = ~w_empty;
  assign w_push      = i_in_valid & ~w_full & ~i_flush;
  assign w_pop       = ~w_empty & i_out_ready & ~i_flush;
  assign o_count     = r_count;
  assign o_afull     = (r_count >= LP_AFULL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + LP_CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - LP_CNT_ONE;
    end
  end

  // Storage is never cleared; empty-state masking below hides stale entries after flush/reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= i_in_pc;
      r_pc4_mem[r_wr_ptr]  <= i_in_pc_plus4;
      r_inst_mem[r_wr_ptr] <= i_in_inst;
      r_mis_mem[r_wr_ptr]  <= i_in_misaligned;
    end
  end

  always_comb begin
    o_out_pc         = '0;
    o_out_pc_plus4   = '0;
    o_out_inst       = NOP_INST;
    o_out_misaligned = 1'b0;
    if (!w_empty) begin
      o_out_pc         = r_pc_mem[r_rd_ptr];
      o_out_pc_plus4   = r_pc4_mem[r_rd_ptr];
      o_out_inst       = r_inst_mem[r_rd_ptr];
      o_out_misaligned = r_mis_mem[r_rd_ptr];
    end
  end

  always @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (r_count <= LP_FULL) else $error("fetch queue count above DEPTH");
      assert (!(w_push && !w_pop && w_full)) else $error("fetch queue overflow");
      assert (!(w_pop && !w_push && w_empty)) else $error("fetch queue underflow");
    end
  end

endmodule

// File: tb/tb_rv_fetch_queue.sv
// tb/tb_rv_fetch_queue.sv - self-checking bench for rv_fetch_queue (DEPTH=4)
module tb_rv_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready, in_mis;
  logic [31:0] in_pc, in_pc4, in_inst;
  logic        out_valid, out_ready, out_mis;
  logic [31:0] out_pc, out_pc4, out_inst;
  logic [2:0]  count;
  logic        afull;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(4), .AFULL_LVL(3), .NOP_INST(32'h0000_0013)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_pc(in_pc), .i_in_pc_plus4(in_pc4), .i_in_inst(in_inst), .i_in_misaligned(in_mis),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_pc(out_pc), .o_out_pc_plus4(out_pc4), .o_out_inst(out_inst), .o_out_misaligned(out_mis),
    .o_count(count), .o_afull(afull)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        mis;
  } ent_t;

  ent_t sb[$];

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
    logic        ordy;
    logic [2:0]  ecount;
    logic        eir;
    logic        eov;
    logic        eaf;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // One clock: drive at negedge, check current state against the model, then advance the model.
  task automatic cyc(input logic fl, input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                     input logic mis, input logic ordy);
    int   n;
    ent_t e;
    @(negedge clk);
    flush = fl; in_valid = iv; in_pc = pc; in_pc4 = pc + 32'd4;
    in_inst = inst; in_mis = mis; out_ready = ordy;
    #1;
    n = sb.size();
    chk("count",     32'(count),     32'(n));
    chk("in_ready",  32'(in_ready),  32'(n != 4));
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    chk("afull",     32'(afull),     32'(n >= 3));
    if (n != 0) begin
      chk("head_pc",   out_pc,        sb[0].pc);
      chk("head_pc4",  out_pc4,       sb[0].pc4);
      chk("head_inst", out_inst,      sb[0].inst);
      chk("head_mis",  32'(out_mis),  32'(sb[0].mis));
    end else begin
      chk("empty_pc",   out_pc,       32'h0);
      chk("empty_pc4",  out_pc4,      32'h0);
      chk("empty_inst", out_inst,     32'h0000_0013);
      chk("empty_mis",  32'(out_mis), 32'h0);
    end
    if (fl) begin
      sb.delete();
    end else begin
      if (ordy && n != 0) void'(sb.pop_front());
      if (iv && n != 4) begin
        e.pc = pc; e.pc4 = pc + 32'd4; e.inst = inst; e.mis = mis;
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_pc4 = '0; in_inst = '0; in_mis = 1'b0;

    //             fl iv pc          inst          mis ordy cnt ir ov af
    tbl[0]  = '{1'b0, 1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 32'h0,   32'h0000_0093, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 32'h4,   32'h0010_0093, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h8,   32'h0020_0093, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'hC,   32'h0030_0093, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 32'h10,  32'h0040_0093, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_count",     32'(count),     32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    chk("rst_afull",     32'(afull),     32'h0);
    chk("rst_inst",      out_inst,       32'h0000_0013);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].inst, tbl[i].mis, tbl[i].ordy);
      chk($sformatf("tbl%0d_count", i),     32'(count),     32'(tbl[i].ecount));
      chk($sformatf("tbl%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].eir));
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
      chk($sformatf("tbl%0d_afull", i),     32'(afull),     32'(tbl[i].eaf));
    end

    // Streaming push+pop at count=2; pointers wrap several times.
    cyc(1'b0, 1'b1, 32'h40, 32'h0400_0013, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h44, 32'h0440_0013, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 32'h48 + 32'(4 * i), 32'h1000_0013 + 32'(i << 7), 1'(i & 1), 1'b1);
      chk("pp_count", 32'(count), 32'h2);
    end
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Full with a simultaneous pop: push refused, slot visible next cycle.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'h80 + 32'(4 * i), 32'h2000_0013 + 32'(i), 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h90, 32'h2222_0013, 1'b0, 1'b1);
    chk("full_pop_ready", 32'(in_ready), 32'h0);
    // Flush at count=3 with a push and pop presented.
    cyc(1'b1, 1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk("pre_flush_count", 32'(count), 32'h3);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("flush_count", 32'(count),     32'h0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_inst",  out_inst,       32'h0000_0013);
    chk("flush_ready", 32'(in_ready),  32'h1);

    // Load-hazard stall with head at 0x20.
    cyc(1'b0, 1'b1, 32'h20, 32'h0020_0013, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h24, 32'h0024_0013, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("stall_pc", out_pc, 32'h20);
    end
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("after_stall_pc",    out_pc,     32'h24);
    chk("after_stall_count", 32'(count), 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset between edges with count=3.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h200 + 32'(4 * i), 32'h3000_0013 + 32'(i), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_arst_count", 32'(count), 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_count",     32'(count),     32'h0);
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_in_ready",  32'(in_ready),  32'h1);
    chk("arst_afull",     32'(afull),     32'h0);
    chk("arst_inst",      out_inst,       32'h0000_0013);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 32'h300, 32'h0030_0013, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_fetch_queue.md
Name: rv_fetch_queue

Overview:
- Parametrised instruction fetch queue replacing the single-entry IF/ID pipeline register of the RV32I core.
- Decouples IF from ID. Buffers up to DEPTH fetched entries, each holding {pc, pc+4, instruction, misaligned flag}.
- Uses a valid/ready handshake on both sides.
- Supports a single-cycle flush on a branch redirect.
- ID stall (load hazard) is expressed by deasserting out_ready, not by a register enable.

Parameters:
- XLEN, 32, width of the pc and pc+4 fields.
- ILEN, 32, instruction width.
- DEPTH, 4, number of entries. Must be a power of two and at least 2.
- AFULL_LVL, DEPTH-1, occupancy at or above which afull asserts. Range 1..DEPTH.
- NOP_INST, 32'h0000_0013, instruction driven on out_inst when the queue is empty (addi x0,x0,0).

Ports:
- clk, in, 1, core clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- flush, in, 1, branch redirect. Discards all entries.
- in_valid, in, 1, IF presents an entry.
- in_ready, out, 1, queue can accept an entry.
- in_pc, in, XLEN, pc of the fetched instruction.
- in_pc_plus4, in, XLEN, pc+4.
- in_inst, in, ILEN, fetched instruction.
- in_misaligned, in, 1, misaligned-pc flag from IF.
- out_valid, out, 1, head entry is valid.
- out_ready, in, 1, ID consumes the head. Driven low during a load hazard.
- out_pc, out, XLEN, head pc.
- out_pc_plus4, out, XLEN, head pc+4.
- out_inst, out, ILEN, head instruction, or NOP_INST when empty.
- out_misaligned, out, 1, head misaligned flag. 0 when empty.
- count, out, $clog2(DEPTH+1), current occupancy.
- afull, out, 1, asserted when count >= AFULL_LVL.

Behaviour:
- Storage and pointers:
  - Circular buffer of DEPTH entries.
  - wr_ptr and rd_ptr are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is a separate register, 0..DEPTH.
- Handshake definitions:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
- Readiness and validity:
  - in_ready = (count != DEPTH). It depends only on registered state; there is no combinational path from out_ready.
  - out_valid = (count != 0).
  - Head fields are read combinationally from entry[rd_ptr].
  - When count==0: out_inst=NOP_INST, out_pc=0, out_pc_plus4=0, out_misaligned=0.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1. There is no bypass path through an empty queue.
- Occupancy update, per clock edge:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Full: in_ready=0, so the push is refused. A pop in the same cycle frees a slot, which is visible as in_ready=1 in the next cycle.
- Empty: out_valid=0. out_ready is ignored.
- Flush (highest priority):
  - At the next edge, count=0 and wr_ptr=rd_ptr=0.
  - Any push or pop presented in the flush cycle is discarded.
  - Entry storage is not cleared; the empty-state output masking hides stale data.
  - In the cycle after flush: out_valid=0, in_ready=1.
- Reset (rst_n low, asynchronous, including mid-operation):
  - Immediately: count=0, pointers=0, out_valid=0, in_ready=1, afull=0.
  - Outputs show the empty-state values.
  - Storage contents need no reset.
- afull is combinational from count and is used by IF to throttle prefetch.
- Pointer and count arithmetic is unsigned modulo its own width. count never exceeds DEPTH or underflows below 0; assertions check both.

Test Plan:
- Reset then single push, DEPTH=4:
  - Stimulus: release rst_n, push {pc=0x100, pc4=0x104, inst=0x00500093}.
  - Required: out_valid=0 in the push cycle; next cycle out_valid=1, out_inst=0x00500093, count=1.
- Fill to full:
  - Stimulus: 4 pushes with pcs 0x0,0x4,0x8,0xC and out_ready=0.
  - Required: count=4, in_ready=0, afull=1. A 5th push (pc 0x10) is refused. Draining yields 0x0,0x4,0x8,0xC in order.
- Simultaneous push and pop:
  - Stimulus: count=2, continuous push/pop for 10 cycles.
  - Required: count stays 2, pointers wrap past 3→0, output order matches input order.
- Flush:
  - Stimulus: count=3, assert flush together with in_valid=1 and out_ready=1.
  - Required: next cycle count=0, out_valid=0, out_inst=0x00000013, and the flush-cycle entry is never seen.
- Load-hazard stall:
  - Stimulus: out_ready=0 for 3 cycles with the head at pc 0x20.
  - Required: out_pc holds 0x20 throughout. When out_ready rises, 0x20 pops exactly once.
- Asynchronous reset mid-operation:
  - Stimulus: with count=3, pull rst_n low between clock edges.
  - Required: count=0, out_valid=0, in_ready=1 before the next edge.
